// File: rtl/alu_instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer_if
//   Control bundle between the hardwired ALU-instruction sequencer and the
//   Phase 1 CPU datapath.
//   master : the sequencer. Samples run/IR and drives every control strobe.
//   slave  : the datapath/environment. Drives run/IR and consumes strobes.
//   Signals: run, IR[31:0] (to sequencer); PC/MAR, MDR/IR, Y/Z/HI/LO
//   enables, Rin/Rout[15:0] one-hot, alu_sel[12:0] one-hot, done, illegal.
// ---------------------------------------------------------------------------
interface alu_instr_sequencer_if;
    logic        run;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin;
    logic        MDMuxread, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [12:0] alu_sel;
    logic        done;
    logic        illegal;

    modport master (
        input  run, IR,
        output PCout, PCin, IncPC, MARin,
        output MDMuxread, MDRin, MDRout, IRin,
        output Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        output Rin, Rout, alu_sel, done, illegal
    );

    modport slave (
        output run, IR,
        input  PCout, PCin, IncPC, MARin,
        input  MDMuxread, MDRin, MDRout, IRin,
        input  Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        input  Rin, Rout, alu_sel, done, illegal
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instr_sequencer
//   Hardwired control-step sequencer for register-register ALU instructions.
//   Steps IDLE -> T0..T5 (T6 for MUL/DIV) and drives the datapath controls.
//   Undefined opcodes park the block in HALT with illegal=1 until clear.
//   Ports:
//     clock : rising-edge clock
//     clear : synchronous active-high reset, forces IDLE from any state
//     bus   : alu_instr_sequencer_if.master (run/IR in, control strobes out)
// ---------------------------------------------------------------------------
module alu_instr_sequencer #(
    parameter int OPW = 5,
    parameter int RW  = 4
) (
    input  logic                         clock,
    input  logic                         clear,
    alu_instr_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_BIN, C_UNA, C_MD, C_ILL
    } cls_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(7);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(8);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(9);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(10);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);

    localparam int LSB_UNUSED = 31 - OPW - 3 * RW;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;

    logic [OPW-1:0] op;
    logic [RW-1:0]  ra, rb, rc;
    cls_t           op_cls;
    logic [12:0]    alu_dec;
    logic           unused_ir_bits;

    assign op = bus.IR[31 -: OPW];
    assign ra = bus.IR[31 - OPW -: RW];
    assign rb = bus.IR[31 - OPW - RW -: RW];
    assign rc = bus.IR[31 - OPW - 2 * RW -: RW];
    assign unused_ir_bits = ^bus.IR[LSB_UNUSED:0];

    function automatic logic [15:0] reg_onehot(input logic [RW-1:0] idx);
        return 16'(1) << idx;
    endfunction

    // Opcode decode: instruction class plus the ALU strobe bit.
    // alu_sel bit order is NOT..ADD from [12] down to [0], so ROL/ROR swap
    // relative to their opcode order.
    always_comb begin
        op_cls  = C_ILL;
        alu_dec = '0;
        case (op)
            OP_ADD:  begin op_cls = C_BIN; alu_dec = 13'h0001; end
            OP_SUB:  begin op_cls = C_BIN; alu_dec = 13'h0002; end
            OP_AND:  begin op_cls = C_BIN; alu_dec = 13'h0004; end
            OP_OR:   begin op_cls = C_BIN; alu_dec = 13'h0008; end
            OP_ROR:  begin op_cls = C_BIN; alu_dec = 13'h0010; end
            OP_ROL:  begin op_cls = C_BIN; alu_dec = 13'h0020; end
            OP_SHR:  begin op_cls = C_BIN; alu_dec = 13'h0040; end
            OP_SHRA: begin op_cls = C_BIN; alu_dec = 13'h0080; end
            OP_SHL:  begin op_cls = C_BIN; alu_dec = 13'h0100; end
            OP_MUL:  begin op_cls = C_MD;  alu_dec = 13'h0200; end
            OP_DIV:  begin op_cls = C_MD;  alu_dec = 13'h0400; end
            OP_NEG:  begin op_cls = C_UNA; alu_dec = 13'h0800; end
            OP_NOT:  begin op_cls = C_UNA; alu_dec = 13'h1000; end
            default: begin op_cls = C_ILL; alu_dec = '0;       end
        endcase
    end

    // The instruction class is captured once in T3; later steps branch on
    // the captured class rather than re-evaluating the opcode.
    assign cls_d = (state_q == S_T3) ? op_cls : cls_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cls_q   <= C_BIN;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // run is only looked at in IDLE and in the final step of an instruction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (op_cls == C_ILL) ? S_HALT : S_T4;
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (cls_q == C_MD) state_d = S_T6;
                else               state_d = bus.run ? S_T0 : S_IDLE;
            end
            S_T6:   state_d = bus.run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDMuxread = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.Rin       = '0;
        bus.Rout      = '0;
        bus.alu_sel   = '0;
        bus.done      = 1'b0;
        bus.illegal   = 1'b0;
        case (state_q)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout   = 1'b1;
                bus.PCin      = 1'b1;
                bus.MDMuxread = 1'b1;
                bus.MDRin     = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                // Illegal opcodes leave T3 completely quiet on the way to HALT.
                if (op_cls != C_ILL) begin
                    bus.Rout = reg_onehot(rb);
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                // Unary ops take their single operand from Rb; Rc is ignored.
                bus.Rout    = (cls_q == C_UNA) ? reg_onehot(rb) : reg_onehot(rc);
                bus.alu_sel = alu_dec;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = (cls_q == C_MD);
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (cls_q == C_MD) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin  = reg_onehot(ra);
                    bus.done = 1'b1;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
            end
            S_HALT: bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    alu_instr_sequencer_if bus();

    alu_instr_sequencer #(.OPW(5), .RW(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    localparam int B_PCOUT = 16, B_PCIN = 15, B_INCPC = 14, B_MARIN = 13;
    localparam int B_MDMUX = 12, B_MDRIN = 11, B_MDROUT = 10, B_IRIN = 9;
    localparam int B_YIN = 8, B_ZLOWIN = 7, B_ZHIGHIN = 6, B_ZLOWOUT = 5;
    localparam int B_ZHIGHOUT = 4, B_HIIN = 3, B_LOIN = 2, B_DONE = 1, B_ILL = 0;

    typedef struct packed {
        logic [16:0] ctl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] alu;
    } obs_t;

    int tests = 0;
    int fails = 0;

    function automatic obs_t sample();
        obs_t o;
        o.ctl  = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDMuxread,
                  bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin,
                  bus.Zhighin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin,
                  bus.done, bus.illegal};
        o.rin  = bus.Rin;
        o.rout = bus.Rout;
        o.alu  = bus.alu_sel;
        return o;
    endfunction

    // ALU strobe position for an opcode, listed in alu_sel bit order
    // ADD,SUB,AND,OR,ROR,ROL,SHR,SHRA,SHL,MUL,DIV,NEG,NOT. -1 = undefined.
    function automatic int alu_bit(input logic [4:0] op);
        logic [4:0] tbl [13];
        tbl = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd7, 5'd9, 5'd10, 5'd11,
                5'd15, 5'd16, 5'd17, 5'd18};
        for (int i = 0; i < 13; i++) if (tbl[i] == op) return i;
        return -1;
    endfunction

    // Steps per instruction: binary/unary 6, MUL/DIV 7, illegal 4 (T0..T3).
    function automatic int n_steps(input logic [31:0] ir);
        int b = alu_bit(ir[31:27]);
        if (b < 0) return 4;
        if (b == 9 || b == 10) return 7;
        return 6;
    endfunction

    function automatic obs_t expect_step(input logic [31:0] ir, input int k);
        obs_t e;
        int   b;
        bit   md, un;
        b  = alu_bit(ir[31:27]);
        md = (b == 9 || b == 10);
        un = (b == 11 || b == 12);
        e  = '0;
        case (k)
            0: begin e.ctl[B_PCOUT] = 1; e.ctl[B_MARIN] = 1; e.ctl[B_INCPC] = 1; e.ctl[B_ZLOWIN] = 1; end
            1: begin e.ctl[B_ZLOWOUT] = 1; e.ctl[B_PCIN] = 1; e.ctl[B_MDMUX] = 1; e.ctl[B_MDRIN] = 1; end
            2: begin e.ctl[B_MDROUT] = 1; e.ctl[B_IRIN] = 1; end
            3: if (b >= 0) begin e.rout[ir[22:19]] = 1; e.ctl[B_YIN] = 1; end
            4: begin
                if (un) e.rout[ir[22:19]] = 1;
                else    e.rout[ir[18:15]] = 1;
                e.alu[b] = 1;
                e.ctl[B_ZLOWIN] = 1;
                e.ctl[B_ZHIGHIN] = md;
            end
            5: begin
                e.ctl[B_ZLOWOUT] = 1;
                if (md) e.ctl[B_LOIN] = 1;
                else begin e.rin[ir[26:23]] = 1; e.ctl[B_DONE] = 1; end
            end
            6: begin e.ctl[B_ZHIGHOUT] = 1; e.ctl[B_HIIN] = 1; e.ctl[B_DONE] = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        logic ok;
        got = sample();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        ok = $onehot0(got.rin) && $onehot0(got.rout) && !((|got.rin) && (|got.rout)) &&
             $onehot0({got.ctl[B_PCOUT], got.ctl[B_MDROUT], got.ctl[B_ZLOWOUT],
                       got.ctl[B_ZHIGHOUT], |got.rout});
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s_invariant got=%h exp=onehot-bus", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One instruction. IR carries junk during T0..T2 since the opcode only
    // matters from T3; run is randomized until the final step.
    task automatic run_instr(input logic [31:0] ir, input bit from_idle,
                             input bit hold, input string tag);
        int n;
        n = n_steps(ir);
        if (from_idle) begin
            bus.run = 1'b1;
            check($sformatf("%s_idle", tag), '0);
            tick();
        end
        for (int k = 0; k < n; k++) begin
            bus.IR = (k < 3) ? $urandom() : ir;
            #1;
            check($sformatf("%s_T%0d", tag, k), expect_step(ir, k));
            bus.run = (k == n - 1) ? hold : 1'($urandom_range(0, 1));
            tick();
        end
        if (n != 4 && !hold) check($sformatf("%s_after", tag), '0);
    endtask

    initial begin
        logic [31:0] ir;
        logic [4:0]  legal [13];
        logic [4:0]  bad [3];
        obs_t        halt_exp;
        bit          prev_hold;
        bit          h;

        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18};
        bad   = '{5'd31, 5'd12, 5'd0};
        halt_exp = '0;
        halt_exp.ctl[B_ILL] = 1'b1;

        clear   = 1'b1;
        bus.run = 1'b0;
        bus.IR  = '0;
        tick();
        tick();
        clear = 1'b0;
        check("reset", '0);
        tick();
        check("idle_no_run", '0);

        // Directed cases from the instruction examples.
        run_instr(32'h4091_8000, 1'b1, 1'b0, "ror");
        run_instr(32'h1AB3_8000, 1'b1, 1'b1, "add");
        run_instr(32'h7823_0000, 1'b0, 1'b1, "mul");
        run_instr(32'h914C_8000, 1'b0, 1'b0, "not");

        // Random legal instructions, randomly back-to-back or from IDLE.
        prev_hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ir = $urandom();
            ir[31:27] = legal[$urandom_range(0, 12)];
            h = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr(ir, !prev_hold, h, $sformatf("rnd%0d", i));
            prev_hold = h;
        end

        // Reset in T4 of a ROR abandons it; Rin must never pulse.
        bus.run = 1'b1;
        bus.IR  = 32'h4091_8000;
        tick();
        bus.run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rstmid_T%0d", k), expect_step(32'h4091_8000, k));
            tick();
            if (k == 3) clear = 1'b1;
        end
        clear = 1'b0;
        check("rstmid_idle", '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstmid_quiet%0d", k), '0);
        end
        run_instr(32'h4091_8000, 1'b1, 1'b0, "restart");

        // Undefined opcodes: quiet T3, then HALT until clear.
        for (int j = 0; j < 3; j++) begin
            ir = $urandom();
            ir[31:27] = bad[j];
            run_instr(ir, 1'b1, 1'b1, $sformatf("ill%0d", j));
            for (int c = 0; c < 10; c++) begin
                bus.run = 1'b1;
                bus.IR  = $urandom();
                #1;
                check($sformatf("ill%0d_halt%0d", j, c), halt_exp);
                tick();
            end
            clear = 1'b1;
            tick();
            clear   = 1'b0;
            bus.run = 1'b0;
            check($sformatf("ill%0d_clear", j), '0);
            tick();
            check($sformatf("ill%0d_idle", j), '0);
        end

        run_instr(32'h914C_8000, 1'b1, 1'b0, "post_ill");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
